gmii_rx_frame_parser: RTL
=========================

Name: gmii_rx_frame_parser

Overview:
Consumes the GMII receive stream from the SGMII PCS/PMA (gmii_rxd/gmii_rx_dv/gmii_rx_er in the sgmii_clk domain) and replaces the minimal RX handler as the first receive stage.
- Strips the preamble and SFD.
- Checks the Ethernet CRC-32 and the frame length.
- Emits the payload (DA through last data byte, FCS removed) as a byte stream with last/error markers for the downstream protocol logic.
- Has no backpressure, because GMII cannot stall.

Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes after SFD, FCS included.
- MAX_LEN, 1518: maximum legal frame length in bytes after SFD, FCS included.

Ports:
- clock  in  1  GMII receive clock (sgmii_clk)
- reset  in  1  synchronous reset, active-high
- gmii_rxd  in  8  receive byte
- gmii_rx_dv  in  1  receive data valid
- gmii_rx_er  in  1  receive error
- out_data  out  8  payload byte
- out_valid  out  1  out_data valid this cycle
- out_last  out  1  final payload byte of the frame; qualified by out_valid
- out_error  out  1  frame bad; meaningful only with out_last
- out_err_code  out  4  {len_long, len_short, crc_bad, rx_er}; meaningful only with out_last

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- While reset is high:
  - all outputs = 0;
  - FSM = IDLE;
  - the delay line is emptied;
  - the length counter is cleared;
  - the CRC register is loaded with 0xFFFFFFFF.
- FSM states: IDLE, PREAMBLE, PAYLOAD, DROP.
  - IDLE: gmii_rx_dv=0 stays in IDLE. With gmii_rx_dv=1:
    - rxd=0x55 goes to PREAMBLE;
    - rxd=0xD5 goes to PAYLOAD (zero-length preamble accepted);
    - any other byte goes to DROP.
  - IDLE: gmii_rx_er while gmii_rx_dv=0 is ignored.
  - PREAMBLE, with gmii_rx_dv=1:
    - 0x55 stays in PREAMBLE (any count);
    - 0xD5 goes to PAYLOAD, with CRC init 0xFFFFFFFF, length 0, sticky error bits cleared;
    - any other byte goes to DROP.
  - PREAMBLE: gmii_rx_dv=0 goes to IDLE and produces no output.
  - PAYLOAD, each byte with gmii_rx_dv=1:
    - the byte is pushed into the 5-byte delay line;
    - CRC is updated;
    - length increments, saturating at 2047;
    - gmii_rx_er=1 sets the sticky rx_er bit.
  - PAYLOAD: when the delay line already holds 5 bytes, each push emits the oldest byte with out_valid=1 and out_last=0.
  - DROP: no output; returns to IDLE on gmii_rx_dv=0.
- Output latency: payload byte k appears on out_data in the cycle after byte k+5 (counted from the first byte after SFD) is sampled.
- End of frame: the first cycle in PAYLOAD that samples gmii_rx_dv=0.
  - If length N >= 5: the delay line holds bytes N-5..N-1.
    - Next cycle, byte N-5 is emitted with out_valid=1 and out_last=1; out_error and out_err_code are valid in the same cycle.
    - Bytes N-4..N-1 (the FCS) are discarded.
  - If N <= 4: no output at all. The frame is counted as bad if statistics are enabled.
  - FSM returns to IDLE in the same cycle, so a new frame starting on the very next cycle is accepted.
- CRC: IEEE 802.3 reflected CRC-32, LSB-first.
  - Polynomial 0xEDB88320, initial value 0xFFFFFFFF, computed over all bytes after SFD including FCS.
  - crc_bad = (final register != 0xDEBB20E3). The register value after the last byte must be usable at the EOF cycle.
- Length checks: len_short = N < MIN_LEN; len_long = N > MAX_LEN.
  - Oversize frames keep streaming, and the error is reported at out_last.
- out_error = OR of the out_err_code bits.
- out_valid is 0 in every cycle that does not emit a byte. out_data is don't-care when out_valid=0.
- Reset mid-frame: output stops immediately and no out_last is produced for that frame.
  - If the remaining bytes of that frame arrive with dv=1 in IDLE and are not 0x55/0xD5, they go to DROP.

Optional Feature:
GMII_RX_STATS_EN
- Defined: adds two outputs, stat_frames_ok (32) and stat_frames_bad (32).
  - Both are saturating counters, cleared by reset.
  - At each frame end: ok increments if N >= 5 and out_error=0; otherwise bad increments. This includes runts with N <= 4 and frames aborted to DROP after SFD.
  - Preamble-only aborts (dv falls while in PREAMBLE) are not counted.
- Undefined: those ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Valid frame: 7×0x55, 0xD5, 60 payload bytes, correct FCS (N=64) -> 60 out_valid bytes, identical to the payload; out_last on the 60th byte; out_error=0, out_err_code=4'b0000; first byte appears 6 cycles after its sampling.
- Same frame with payload byte 10 XORed with 0x01 -> 60 bytes; out_last with out_err_code=4'b0010.
- gmii_rx_er pulsed for 1 cycle on payload byte 20 of a valid frame -> out_err_code=4'b0001 at out_last. A separate 3-cycle gmii_rx_er pulse with dv=0 between frames -> no effect on either frame.
- Runt: SFD + 3 bytes -> no output. Frame with correct CRC and N=40 -> 36 bytes, err_code=4'b0100. Frame with correct CRC and N=1600 -> 1596 bytes, err_code=4'b1000.
- Preamble 0x55,0x55,0x5A,0xD5,… -> no output until dv falls. Back-to-back valid frames separated by a single dv=0 cycle -> both delivered, each with its own out_last.
- Reset asserted for 2 cycles at payload byte 30 of a 100-byte frame -> outputs 0 from the first reset cycle, no out_last. The next valid frame is delivered correctly. With GMII_RX_STATS_EN, the counters read 0 immediately after reset, then ok=1 after the next valid frame.

Source files
------------

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame parser: strips preamble/SFD, checks CRC-32 and length,
// and streams the payload (FCS removed) with last/error markers.
// Optional statistics counters are enabled by defining GMII_RX_STATS_EN.
module gmii_rx_frame_parser #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       out_error,
  output logic [3:0] out_err_code
`ifdef GMII_RX_STATS_EN
  ,
  output logic [31:0] stat_frames_ok,
  output logic [31:0] stat_frames_bad
`endif
);

  localparam int unsigned LEN_W = 11;
  localparam int unsigned DLY_N = 5;
  localparam int unsigned FILL_W = 3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [LEN_W-1:0] LEN_SAT = '1;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_e;

  state_e                      state_q;
  logic [DLY_N-1:0][7:0]       dly_q;
  logic [FILL_W-1:0]           fill_q;
  logic [LEN_W-1:0]            len_q;
  logic [LEN_W-1:0]            len_d;
  logic [31:0]                 crc_q;
  logic [31:0]                 crc_d;
  logic                        rx_er_q;
  logic                        dly_full;
  logic [3:0]                  eof_code;

  // Byte-wide reflected CRC-32 update and saturating length increment
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 8; i++) begin
      crc_d = (crc_d >> 1) ^ (((crc_d[0] ^ gmii_rxd[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    len_d    = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
    dly_full = (fill_q == FILL_W'(DLY_N));
    eof_code = {(32'(len_q) > MAX_LEN), (32'(len_q) < MIN_LEN),
                (crc_q != CRC_RESIDUE), rx_er_q};
  end

  // Frame FSM, delay line, checkers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      dly_q        <= '0;
      fill_q       <= '0;
      len_q        <= '0;
      crc_q        <= CRC_INIT;
      rx_er_q      <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_error    <= 1'b0;
      out_err_code <= '0;
`ifdef GMII_RX_STATS_EN
      stat_frames_ok  <= '0;
      stat_frames_bad <= '0;
`endif
    end else begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_error    <= 1'b0;
      out_err_code <= '0;
      case (state_q)
        IDLE, PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state_q <= IDLE;
          end else if (gmii_rxd == PRE_BYTE) begin
            state_q <= PREAMBLE;
          end else if (gmii_rxd == SFD_BYTE) begin
            state_q <= PAYLOAD;
            crc_q   <= CRC_INIT;
            len_q   <= '0;
            rx_er_q <= 1'b0;
            fill_q  <= '0;
          end else begin
            state_q <= DROP;
          end
        end
        PAYLOAD: begin
          if (gmii_rx_dv) begin
            dly_q  <= {dly_q[DLY_N-2:0], gmii_rxd};
            fill_q <= dly_full ? fill_q : fill_q + FILL_W'(1);
            crc_q  <= crc_d;
            len_q  <= len_d;
            if (gmii_rx_er) begin
              rx_er_q <= 1'b1;
            end
            if (dly_full) begin
              out_valid <= 1'b1;
              out_data  <= dly_q[DLY_N-1];
            end
          end else begin
            state_q <= IDLE;
            fill_q  <= '0;
            if (dly_full) begin
              out_valid    <= 1'b1;
              out_last     <= 1'b1;
              out_data     <= dly_q[DLY_N-1];
              out_error    <= |eof_code;
              out_err_code <= eof_code;
            end
`ifdef GMII_RX_STATS_EN
            if (dly_full && (eof_code == 4'b0000)) begin
              if (stat_frames_ok != '1) begin
                stat_frames_ok <= stat_frames_ok + 32'(1);
              end
            end else if (stat_frames_bad != '1) begin
              stat_frames_bad <= stat_frames_bad + 32'(1);
            end
`endif
          end
        end
        DROP: begin
          if (!gmii_rx_dv) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
